// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the RV32I execute unit.
//   XLEN     - datapath width
//   NUM_OPS  - width of the one-hot decoded instruction bus
//   OP_W     - width of an encoded op index
//   OP_*     - bit position of each instruction on the one-hot bus
package alu_pkg;

    localparam int XLEN    = 32;
    localparam int NUM_OPS = 37;
    localparam int OP_W    = 6;

    localparam logic [OP_W-1:0] OP_ADD   = 6'd0;
    localparam logic [OP_W-1:0] OP_SUB   = 6'd1;
    localparam logic [OP_W-1:0] OP_SLL   = 6'd2;
    localparam logic [OP_W-1:0] OP_SLT   = 6'd3;
    localparam logic [OP_W-1:0] OP_SLTU  = 6'd4;
    localparam logic [OP_W-1:0] OP_XOR   = 6'd5;
    localparam logic [OP_W-1:0] OP_SRL   = 6'd6;
    localparam logic [OP_W-1:0] OP_SRA   = 6'd7;
    localparam logic [OP_W-1:0] OP_OR    = 6'd8;
    localparam logic [OP_W-1:0] OP_AND   = 6'd9;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'd10;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'd11;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'd12;
    localparam logic [OP_W-1:0] OP_XORI  = 6'd13;
    localparam logic [OP_W-1:0] OP_ORI   = 6'd14;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'd15;
    localparam logic [OP_W-1:0] OP_SLLI  = 6'd16;
    localparam logic [OP_W-1:0] OP_SRLI  = 6'd17;
    localparam logic [OP_W-1:0] OP_SRAI  = 6'd18;
    localparam logic [OP_W-1:0] OP_LB    = 6'd19;
    localparam logic [OP_W-1:0] OP_LH    = 6'd20;
    localparam logic [OP_W-1:0] OP_LW    = 6'd21;
    localparam logic [OP_W-1:0] OP_LBU   = 6'd22;
    localparam logic [OP_W-1:0] OP_LHU   = 6'd23;
    localparam logic [OP_W-1:0] OP_SB    = 6'd24;
    localparam logic [OP_W-1:0] OP_SH    = 6'd25;
    localparam logic [OP_W-1:0] OP_SW    = 6'd26;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'd27;
    localparam logic [OP_W-1:0] OP_BNE   = 6'd28;
    localparam logic [OP_W-1:0] OP_BLT   = 6'd29;
    localparam logic [OP_W-1:0] OP_BGE   = 6'd30;
    localparam logic [OP_W-1:0] OP_BLTU  = 6'd31;
    localparam logic [OP_W-1:0] OP_BGEU  = 6'd32;
    localparam logic [OP_W-1:0] OP_LUI   = 6'd33;
    localparam logic [OP_W-1:0] OP_AUIPC = 6'd34;
    localparam logic [OP_W-1:0] OP_JAL   = 6'd35;
    localparam logic [OP_W-1:0] OP_JALR  = 6'd36;

endpackage

// File: rtl/alu_branch_cmp.sv
// alu_branch_cmp: branch condition evaluation plus the shared comparator.
//   v1, v2      - operands
//   branch      - branch op bits, [0]=BEQ [1]=BNE [2]=BLT [3]=BGE [4]=BLTU [5]=BGEU
//   taken       - selected branch condition holds
//   lt_signed   - signed v1 < v2 (reused by SLT/SLTI)
//   lt_unsigned - unsigned v1 < v2 (reused by SLTU/SLTIU)
module alu_branch_cmp
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] v1,
    input  logic [XLEN-1:0] v2,
    input  logic [5:0]      branch,
    output logic            taken,
    output logic            lt_signed,
    output logic            lt_unsigned
);

    logic eq;

    assign eq          = (v1 == v2);
    assign lt_signed   = ($signed(v1) < $signed(v2));
    assign lt_unsigned = (v1 < v2);

    // Lowest branch bit wins, matching the top-level priority order.
    always_comb begin
        taken = 1'b0;
        if (branch[0])      taken = eq;
        else if (branch[1]) taken = ~eq;
        else if (branch[2]) taken = lt_signed;
        else if (branch[3]) taken = ~lt_signed;
        else if (branch[4]) taken = lt_unsigned;
        else if (branch[5]) taken = ~lt_unsigned;
    end

endmodule

// File: rtl/alu.sv
// alu: registered RV32I execute unit driven by a one-hot instruction bus.
//   clk          - clock, rising edge
//   rst_n        - asynchronous active-low reset, clears ALUoutput
//   v1, v2       - operands (selected upstream)
//   instructions - one-hot decoded op; lowest set bit wins, zero is a bubble
//   ALUoutput    - result, registered one cycle after the inputs
module alu
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [XLEN-1:0]    v1,
    input  logic [XLEN-1:0]    v2,
    input  logic [NUM_OPS-1:0] instructions,
    output logic [XLEN-1:0]    ALUoutput
);

    logic [OP_W-1:0] sel_idx;
    logic            sel_valid;
    logic            taken;
    logic            lt_signed;
    logic            lt_unsigned;
    logic [4:0]      shamt;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] result_next;

    alu_branch_cmp u_branch_cmp (
        .v1          (v1),
        .v2          (v2),
        .branch      (instructions[OP_BGEU:OP_BEQ]),
        .taken       (taken),
        .lt_signed   (lt_signed),
        .lt_unsigned (lt_unsigned)
    );

    // Scan from the top down so the lowest set bit is the last to assign.
    always_comb begin
        sel_idx   = '0;
        sel_valid = 1'b0;
        for (int i = NUM_OPS - 1; i >= 0; i--) begin
            if (instructions[i]) begin
                sel_idx   = i[OP_W-1:0];
                sel_valid = 1'b1;
            end
        end
    end

    assign shamt = v2[4:0];
    assign sum   = v1 + v2;

    always_comb begin
        result_next = '0;
        if (sel_valid) begin
            case (sel_idx)
                OP_ADD, OP_ADDI, OP_AUIPC,
                OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
                OP_SB, OP_SH, OP_SW:             result_next = sum;
                OP_SUB:                          result_next = v1 - v2;
                OP_SLL, OP_SLLI:                 result_next = v1 << shamt;
                OP_SRL, OP_SRLI:                 result_next = v1 >> shamt;
                OP_SRA, OP_SRAI:                 result_next = $unsigned($signed(v1) >>> shamt);
                OP_SLT, OP_SLTI:                 result_next = {{(XLEN-1){1'b0}}, lt_signed};
                OP_SLTU, OP_SLTIU:               result_next = {{(XLEN-1){1'b0}}, lt_unsigned};
                OP_XOR, OP_XORI:                 result_next = v1 ^ v2;
                OP_OR, OP_ORI:                   result_next = v1 | v2;
                OP_AND, OP_ANDI:                 result_next = v1 & v2;
                OP_BEQ, OP_BNE, OP_BLT,
                OP_BGE, OP_BLTU, OP_BGEU:        result_next = {{(XLEN-1){1'b0}}, taken};
                OP_LUI:                          result_next = v2;
                OP_JAL, OP_JALR:                 result_next = v1 + 32'd4;
                default:                         result_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ALUoutput <= '0;
        else        ALUoutput <= result_next;
    end

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for alu.
module tb_alu;
    import alu_pkg::*;

    logic               clk;
    logic               rst_n;
    logic [XLEN-1:0]    v1;
    logic [XLEN-1:0]    v2;
    logic [NUM_OPS-1:0] instructions;
    logic [XLEN-1:0]    ALUoutput;

    int checks_total;
    int checks_passed;

    alu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .v1           (v1),
        .v2           (v2),
        .instructions (instructions),
        .ALUoutput    (ALUoutput)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] expected);
        checks_total++;
        assert (ALUoutput === expected) checks_passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, ALUoutput, expected);
        $display("check %-14s observed 0x%08h expected 0x%08h", tag, ALUoutput, expected);
    endtask

    // Apply one instruction, wait for the capturing edge, then check.
    task automatic run_op(input string tag, input int bitpos, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] expected);
        logic [NUM_OPS-1:0] w;
        w = '0;
        if (bitpos >= 0) w[bitpos] = 1'b1;
        v1 = a;
        v2 = b;
        instructions = w;
        @(posedge clk);
        #1;
        check(tag, expected);
    endtask

    task automatic run_raw(input string tag, input logic [NUM_OPS-1:0] w, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic [XLEN-1:0] expected);
        v1 = a;
        v2 = b;
        instructions = w;
        @(posedge clk);
        #1;
        check(tag, expected);
    endtask

    // R-type and I-type expectations for v1=5, v2=4, indexed by op bit 0..18.
    logic [XLEN-1:0] sweep_exp [0:18];

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        sweep_exp = '{32'd9, 32'd1, 32'h50, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd5, 32'd4,
                      32'd9, 32'd0, 32'd0, 32'd1, 32'd5, 32'd4, 32'h50, 32'd0, 32'd0};

        rst_n = 1'b0;
        v1 = '0;
        v2 = '0;
        instructions = '0;
        #1;
        check("reset_state", 32'h0);
        #9;
        rst_n = 1'b1;

        // Make the output nonzero, then reset between edges.
        run_op("pre_reset_add", int'(OP_ADD), 32'd5, 32'd4, 32'd9);
        #10;
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'h0);
        #5;
        rst_n = 1'b1;
        run_op("bubble_after_rst", -1, 32'd5, 32'd4, 32'h0);

        for (int i = 0; i <= 18; i++)
            run_op($sformatf("sweep_bit%0d", i), i, 32'd5, 32'd4, sweep_exp[i]);

        // Sign handling.
        run_op("sra_neg",  int'(OP_SRA),  32'hFFFFFFF0, 32'd4, 32'hFFFFFFFF);
        run_op("srl_neg",  int'(OP_SRL),  32'hFFFFFFF0, 32'd4, 32'h0FFFFFFF);
        run_op("slt_neg",  int'(OP_SLT),  32'hFFFFFFF0, 32'd4, 32'd1);
        run_op("sltu_neg", int'(OP_SLTU), 32'hFFFFFFF0, 32'd4, 32'd0);
        run_op("sub_neg",  int'(OP_SUB),  32'hFFFFFFF0, 32'd4, 32'hFFFFFFEC);
        run_op("srai_neg", int'(OP_SRAI), 32'h80000000, 32'd31, 32'hFFFFFFFF);

        // Shift-amount masking and wraparound.
        run_op("sll_mask", int'(OP_SLL), 32'd1, 32'h24, 32'h10);
        run_op("add_wrap", int'(OP_ADD), 32'hFFFFFFFF, 32'd1, 32'h0);

        // Branches.
        run_op("beq",      int'(OP_BEQ),  32'd5, 32'd4, 32'd0);
        run_op("bne",      int'(OP_BNE),  32'd5, 32'd4, 32'd1);
        run_op("blt",      int'(OP_BLT),  32'd5, 32'd4, 32'd0);
        run_op("bge",      int'(OP_BGE),  32'd5, 32'd4, 32'd1);
        run_op("bltu",     int'(OP_BLTU), 32'd5, 32'd4, 32'd0);
        run_op("bgeu",     int'(OP_BGEU), 32'd5, 32'd4, 32'd1);
        run_op("beq_eq",   int'(OP_BEQ),  32'd7, 32'd7, 32'd1);
        run_op("bge_eq",   int'(OP_BGE),  32'd7, 32'd7, 32'd1);
        run_op("blt_neg",  int'(OP_BLT),  32'hFFFFFFF0, 32'd4, 32'd1);
        run_op("bltu_neg", int'(OP_BLTU), 32'hFFFFFFF0, 32'd4, 32'd0);

        // Upper immediate, link address, memory address.
        run_op("lui",   int'(OP_LUI),   32'hDEAD0000, 32'h12345000, 32'h12345000);
        run_op("auipc", int'(OP_AUIPC), 32'h1000, 32'h2000, 32'h3000);
        run_op("jal",   int'(OP_JAL),   32'h100, 32'h55, 32'h104);
        run_op("jalr",  int'(OP_JALR),  32'h200, 32'h55, 32'h204);
        run_op("lw",    int'(OP_LW),    32'h1000, 32'hFFFFFFFC, 32'hFFC);
        run_op("sb",    int'(OP_SB),    32'h2000, 32'h10, 32'h2010);

        // Multi-hot priority, then bubble.
        run_raw("multi_hot_0x3", 37'h3, 32'd5, 32'd4, 32'd9);
        run_raw("multi_beq_jalr", (37'd1 << OP_BEQ) | (37'd1 << OP_JALR), 32'd7, 32'd7, 32'd1);
        run_op("bubble", -1, 32'd5, 32'd4, 32'h0);

        // Nonzero result, then reset between edges.
        run_raw("multi_hot_again", 37'h3, 32'd5, 32'd4, 32'd9);
        #10;
        rst_n = 1'b0;
        #1;
        check("async_reset_2", 32'h0);
        @(posedge clk);
        #1;
        check("held_in_reset", 32'h0);
        rst_n = 1'b1;
        run_op("after_release", int'(OP_OR), 32'hF0, 32'h0F, 32'hFF);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Registered 32-bit integer execute unit for the RV32I core.
- Driven by a one-hot decoded instruction bus from the decode stage, with one bit per RV32I base instruction (37 in total).
- Computes arithmetic and logic results, load/store addresses, branch conditions, LUI/AUIPC values and link addresses.
- Operand selection (register, immediate or PC) is done upstream; the ALU operates only on v1 and v2.

Parameters:
- XLEN, 32, datapath width.
- NUM_OPS, 37, width of the one-hot instruction bus.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- v1  input  32  operand 1 (rs1 or PC).
- v2  input  32  operand 2 (rs2 or sign-extended immediate; for LUI, the immediate pre-shifted to [31:12]).
- instructions  input  37  one-hot decoded opcode (bit map below).
- ALUoutput  output  32  registered result.

Behaviour:
- Bit map:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
  - 10 ADDI, 11 SLTI, 12 SLTIU, 13 XORI, 14 ORI, 15 ANDI, 16 SLLI, 17 SRLI, 18 SRAI
  - 19 LB, 20 LH, 21 LW, 22 LBU, 23 LHU, 24 SB, 25 SH, 26 SW
  - 27 BEQ, 28 BNE, 29 BLT, 30 BGE, 31 BLTU, 32 BGEU
  - 33 LUI, 34 AUIPC, 35 JAL, 36 JALR
- Arithmetic: ADD/ADDI/AUIPC and all loads/stores give v1+v2, modulo 2^32 with no overflow flag. SUB gives v1-v2, modulo 2^32.
- Logic: AND/OR/XOR and their immediate forms are bitwise.
- Shifts: shift amount is v2[4:0]; v2[31:5] is ignored. SLL is logical left. SRL is logical right, zero fill. SRA is arithmetic right, replicating v1[31].
- Set-less-than: SLT/SLTI give 32'd1 if signed v1<v2, else 0. SLTU/SLTIU use the unsigned compare.
- Branches give 32'd1 when taken, else 32'd0:
  - BEQ: v1==v2. BNE: v1!=v2.
  - BLT: signed v1<v2. BGE: signed v1>=v2.
  - BLTU/BGEU: unsigned equivalents.
- LUI gives v2 unchanged.
- JAL/JALR give v1+4 (link address; v1 = PC supplied upstream).
- Latency: ALUoutput is updated on the first rising clk edge after inputs settle, i.e. 1 cycle, and holds until the next edge.
- Reset: rst_n low clears ALUoutput to 32'h0 immediately, independent of clk. Reset mid-operation discards the in-flight result. The first capture after reset release is at the first rising edge with rst_n high.
- instructions == 0 (bubble): ALUoutput is loaded with 32'h0 on the edge.
- Multiple bits set (illegal): the lowest set index wins (priority encode); no error output.
- No handshake; a new operation is accepted every cycle.

Decomposition:
- alu_pkg holds:
  - localparams XLEN and NUM_OPS;
  - one index constant per op (OP_ADD=0 … OP_JALR=36).
- One sub-module, alu_branch_cmp: inputs v1, v2 and the six branch bits; output is the 1-bit taken flag. It shares the signed/unsigned comparator with SLT/SLTU.
- The result mux and output register stay in alu.

Test Plan:
- Reset: drive rst_n=0 with ALUoutput previously nonzero -> ALUoutput=0 immediately, before any clk edge. Release, instructions=0 -> ALUoutput stays 0.
- R-type sweep, v1=5, v2=4, one bit per 50 ns, sampled after the edge:
  - ADD 9, SUB 1, SLL 0x50, SLT 0, SLTU 0;
  - XOR 1, SRL 0, SRA 0, OR 5, AND 4;
  - bits 10–18 give the same results as their R-type counterparts.
- Sign handling, v1=0xFFFFFFF0, v2=4:
  - SRA 0xFFFFFFFF, SRL 0x0FFFFFFF;
  - SLT 1, SLTU 0;
  - SUB 0xFFFFFFEC.
- Shift/wrap boundaries:
  - v2=0x24 with SLL, v1=1 -> 0x10 (only v2[4:0] used);
  - v1=0xFFFFFFFF, v2=1, ADD -> 0.
- Branch/LUI/JAL, v1=5, v2=4:
  - BEQ 0, BNE 1, BLT 0, BGE 1, BLTU 0, BGEU 1;
  - v1=v2=7: BEQ 1;
  - LUI with v2=0x12345000 -> 0x12345000;
  - JAL with v1=0x100 -> 0x104;
  - LW with v1=0x1000, v2=0xFFFFFFFC -> 0xFFC.
- Illegal multi-hot instructions=0x3 -> 9 (ADD priority). Asserting rst_n=0 between edges clears the output immediately.
